pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage core. It owns the `stall_n`, write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch redirects, instruction- and data-memory busy stalls, and halt drain. It sits beside the decode stage and consumes decode-stage register fields plus the EX-stage control bits the ID/EX register already exposes.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles needed for a `HLT` in ID to retire past WB (EX, MEM, WB).
- `PERF_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `id_rs_reg`, `id_rt_reg` in 4: source register numbers of the instruction in ID.
- `id_rs_used`, `id_rt_used` in 1: the ID instruction actually reads rs / rt.
- `id_hlt` in 1: the ID instruction is `HLT`.
- `id_branch_taken` in 1: branch resolved taken in ID this cycle.
- `ex_rd` in 4: destination register of the instruction in EX.
- `ex_memread` in 1: the EX instruction is a load.
- `ex_WriteReg` in 1: the EX instruction writes the register file.
- `if_busy` in 1: instruction memory has not returned a valid fetch.
- `mem_busy` in 1: data memory access in MEM is not complete.
- `pc_wen` out 1: PC register write enable.
- `if_id_stall_n`, `id_ex_stall_n`, `ex_mem_stall_n`, `mem_wb_stall_n` out 1: pipeline register write enables.
- `if_id_flush`, `id_ex_flush` out 1: synchronous bubble insertion into IF/ID and ID/EX.
- `halted` out 1: the core has fully drained after `HLT`.
- `perf_stall_cnt`, `perf_flush_cnt` out `PERF_W`: present only with `PIPE_CTRL_PERF_EN`.

## Operation
- Load-use hazard `lu` is asserted when all of the following hold: `ex_memread`, `ex_WriteReg`, `ex_rd != 0`, and either (`id_rs_used` and `id_rs_reg == ex_rd`) or (`id_rt_used` and `id_rt_reg == ex_rd`).
- Control outputs are combinational from the inputs and the FSM state. Priority runs from highest to lowest:
  1. `mem_busy`: all `stall_n` = 0, `pc_wen` = 0, no flushes. The whole pipe freezes.
  2. `lu`: `pc_wen` = 0, `if_id_stall_n` = 0, `id_ex_flush` = 1. One bubble goes into EX; EX/MEM and MEM/WB advance.
  3. `id_branch_taken`: `pc_wen` = 1 (the target is loaded), `if_id_flush` = 1.
  4. `if_busy`: `pc_wen` = 0, `if_id_flush` = 1. Downstream stages advance.
  5. Otherwise every enable is 1 and every flush is 0.
- FSM states are `RUN`, `DRAIN` and `HALTED`.
  - `RUN` to `DRAIN`: `id_hlt` is high and neither `mem_busy` nor `lu` is active. The drain counter loads `DRAIN_CYCLES`.
  - In `DRAIN`: `pc_wen` = 0 and `if_id_flush` = 1, so no new fetches enter. The counter decrements each cycle `mem_busy` = 0 and holds while `mem_busy` = 1. When the counter reaches 1 and decrements, the FSM moves to `HALTED`.
  - In `HALTED`: `pc_wen` = 0, all `stall_n` = 0, `halted` = 1. This state is left only by reset.
- A taken branch and `id_hlt` cannot coexist, because `HLT` is not a branch. `id_branch_taken` is ignored outside `RUN`.

## Timing
- Reset: while `rst_n` = 0, the controls are `pc_wen` = 0, all `stall_n` = 1, `if_id_flush` = `id_ex_flush` = 1, and `halted` = 0. The FSM is `RUN`, the counter is 0, and the perf counters are 0. Deasserting reset mid-drain returns the FSM to `RUN`.
- Hazard response has zero latency, in the same cycle. A load-use stall lasts exactly one cycle unless `mem_busy` extends it.
- `halted` rises on the cycle after the last drain decrement. With no memory stalls, this is `DRAIN_CYCLES` cycles after `HLT` was in ID.
- If `mem_busy` and `lu` occur together, the freeze wins. `lu` is re-evaluated each cycle and takes effect once `mem_busy` drops.
- If `if_busy` and `lu` occur together, `lu` controls fall back on the cycle the IF/ID register is held.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall_cnt` increments each cycle that `pc_wen` = 0 in `RUN`.
  - `perf_flush_cnt` increments each cycle that `if_id_flush` or `id_ex_flush` is asserted outside reset.
  - Both counters saturate at all-ones and freeze in `HALTED`.
- `PIPE_CTRL_PERF_EN` undefined: the counters and ports are absent. Control behaviour is identical in both builds.

## Structure
- Shared package `pipe_ctrl_pkg`: the state enum (`RUN`, `DRAIN`, `HALTED`), the `DRAIN_CYCLES` default, and the opcode constants for `HLT` (4'b1111) and `LW` (4'b1000).
- One sub-module, `pipe_perf_cnt`: a saturating counter with an increment enable, instantiated twice and only under the macro. All other logic is in this block.

## Test plan
- Load-use hazard: `ex_memread` = 1, `ex_WriteReg` = 1, `ex_rd` = 5, `id_rs_reg` = 5, `id_rs_used` = 1. Expect exactly one cycle of `pc_wen` = 0, `if_id_stall_n` = 0, `id_ex_flush` = 1. With `ex_rd` = 0, expect no stall.
- Data-memory freeze priority: `mem_busy` high for 4 cycles while `lu` is also high. Expect all enables at 0 for 4 cycles, no flush, then one `lu` bubble on the following cycle.
- Taken branch: `id_branch_taken` = 1 with `if_busy` = 1. Expect `pc_wen` = 1 and `if_id_flush` = 1 for that cycle.
- Halt drain: `id_hlt` pulses with no stalls. Expect `halted` = 1 three cycles later. Repeat with `mem_busy` high for 2 cycles during the drain; expect `halted` five cycles later.
- Reset mid-drain: assert `rst_n` = 0 asynchronously while in `DRAIN`. Expect the reset output values immediately and `RUN` after release.
- Perf counters, under `PIPE_CTRL_PERF_EN`: 3 load-use stalls plus 2 branches give `perf_stall_cnt` = 3 and `perf_flush_cnt` = 5. Forcing 2^16 stall cycles holds `perf_stall_cnt` at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the five-stage pipeline sequencing controller:
// controller state encoding, drain default and the opcodes it cares about.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } ctrl_state_t;

   // EX, MEM and WB must empty before the core counts as halted.
   localparam int DRAIN_CYCLES_DEF = 3;

   localparam logic [3:0] OP_HLT = 4'b1111;
   localparam logic [3:0] OP_LW  = 4'b1000;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for the controller performance statistics.
module pipe_perf_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Count enabled events and stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch redirects,
// memory-busy freezes and halt drain for the five-stage core.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int PERF_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] id_rs_reg,
   input  logic [3:0] id_rt_reg,
   input  logic       id_rs_used,
   input  logic       id_rt_used,
   input  logic       id_hlt,
   input  logic       id_branch_taken,
   input  logic [3:0] ex_rd,
   input  logic       ex_memread,
   input  logic       ex_WriteReg,
   input  logic       if_busy,
   input  logic       mem_busy,
   output logic       pc_wen,
   output logic       if_id_stall_n,
   output logic       id_ex_stall_n,
   output logic       ex_mem_stall_n,
   output logic       mem_wb_stall_n,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       halted
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

   localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   ctrl_state_t      state;
   logic [CNT_W-1:0] drain_cnt;
   logic             lu;

   // Load in EX feeding a register the ID instruction actually reads.
   always_comb begin
      lu = ex_memread && ex_WriteReg && (ex_rd != 4'd0) &&
           ((id_rs_used && (id_rs_reg == ex_rd)) ||
            (id_rt_used && (id_rt_reg == ex_rd)));
   end

   // Run/drain/halt sequencing; the drain count stalls with a frozen pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         drain_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (id_hlt && !mem_busy && !lu) begin
                  state     <= DRAIN;
                  drain_cnt <= CNT_W'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               if (!mem_busy) begin
                  drain_cnt <= drain_cnt - CNT_W'(1);
                  if (drain_cnt == CNT_W'(1))
                     state <= HALTED;
               end
            end
            HALTED: ;
            default: state <= RUN;
         endcase
      end
   end

   // Zero-latency pipeline-register controls, highest priority first.
   always_comb begin
      pc_wen         = 1'b1;
      if_id_stall_n  = 1'b1;
      id_ex_stall_n  = 1'b1;
      ex_mem_stall_n = 1'b1;
      mem_wb_stall_n = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      halted         = 1'b0;
      if (!rst_n) begin
         // Hold fetch and keep bubbles flowing while reset is applied.
         pc_wen      = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (state == HALTED) begin
         pc_wen         = 1'b0;
         if_id_stall_n  = 1'b0;
         id_ex_stall_n  = 1'b0;
         ex_mem_stall_n = 1'b0;
         mem_wb_stall_n = 1'b0;
         halted         = 1'b1;
      end else if (mem_busy) begin
         pc_wen         = 1'b0;
         if_id_stall_n  = 1'b0;
         id_ex_stall_n  = 1'b0;
         ex_mem_stall_n = 1'b0;
         mem_wb_stall_n = 1'b0;
      end else if (state == DRAIN) begin
         // Nothing new may enter behind the HLT; branches are ignored here.
         pc_wen      = 1'b0;
         if_id_flush = 1'b1;
      end else if (lu) begin
         pc_wen        = 1'b0;
         if_id_stall_n = 1'b0;
         id_ex_flush   = 1'b1;
      end else if (id_branch_taken) begin
         if_id_flush = 1'b1;
      end else if (if_busy) begin
         pc_wen      = 1'b0;
         if_id_flush = 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic stall_inc;
   logic flush_inc;

   // Event qualifiers; both counters freeze once the core has halted.
   always_comb begin
      stall_inc = rst_n && (state == RUN) && !pc_wen;
      flush_inc = rst_n && (state != HALTED) && (if_id_flush || id_ex_flush);
   end

   pipe_perf_cnt #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .cnt   (perf_stall_cnt)
   );

   pipe_perf_cnt #(.W(PERF_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .cnt   (perf_flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Control outputs are packed as
// {pc_wen, if_id, id_ex, ex_mem, mem_wb stall_n, if_id_flush, id_ex_flush, halted}.
module tb_pipe_hazard_ctrl;

   localparam int PERF_W = 16;

   localparam logic [7:0] V_NORM = 8'b1_1111_00_0;
   localparam logic [7:0] V_FRZ  = 8'b0_0000_00_0;
   localparam logic [7:0] V_LU   = 8'b0_0111_01_0;
   localparam logic [7:0] V_BR   = 8'b1_1111_10_0;
   localparam logic [7:0] V_IFB  = 8'b0_1111_10_0;
   localparam logic [7:0] V_DRN  = 8'b0_1111_10_0;
   localparam logic [7:0] V_HLT  = 8'b0_0000_00_1;
   localparam logic [7:0] V_RST  = 8'b0_1111_11_0;

   typedef struct packed {
      logic       ld;
      logic       wr;
      logic [3:0] rd;
      logic [3:0] rs;
      logic       rsu;
      logic [3:0] rt;
      logic       rtu;
      logic       hlt;
      logic       br;
      logic       ifb;
      logic       mb;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [7:0] v;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] v;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] id_rs_reg = '0, id_rt_reg = '0, ex_rd = '0;
   logic       id_rs_used = 0, id_rt_used = 0, id_hlt = 0, id_branch_taken = 0;
   logic       ex_memread = 0, ex_WriteReg = 0, if_busy = 0, mem_busy = 0;
   logic       pc_wen, if_id_stall_n, id_ex_stall_n, ex_mem_stall_n, mem_wb_stall_n;
   logic       if_id_flush, id_ex_flush, halted;
`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int   n_asserts = 0;
   int   n_fail = 0;
   vec_t vq[$];
   exp_t sb[$];

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .PERF_W(PERF_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs_reg       (id_rs_reg),
      .id_rt_reg       (id_rt_reg),
      .id_rs_used      (id_rs_used),
      .id_rt_used      (id_rt_used),
      .id_hlt          (id_hlt),
      .id_branch_taken (id_branch_taken),
      .ex_rd           (ex_rd),
      .ex_memread      (ex_memread),
      .ex_WriteReg     (ex_WriteReg),
      .if_busy         (if_busy),
      .mem_busy        (mem_busy),
      .pc_wen          (pc_wen),
      .if_id_stall_n   (if_id_stall_n),
      .id_ex_stall_n   (id_ex_stall_n),
      .ex_mem_stall_n  (ex_mem_stall_n),
      .mem_wb_stall_n  (mem_wb_stall_n),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .halted          (halted)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {pc_wen, if_id_stall_n, id_ex_stall_n, ex_mem_stall_n,
              mem_wb_stall_n, if_id_flush, id_ex_flush, halted};
   endfunction

   function automatic stim_t idle_s();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t lu_s(input logic [3:0] r);
      stim_t s;
      s     = '0;
      s.ld  = 1'b1;
      s.wr  = 1'b1;
      s.rd  = r;
      s.rs  = r;
      s.rsu = 1'b1;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      ex_memread      = s.ld;
      ex_WriteReg     = s.wr;
      ex_rd           = s.rd;
      id_rs_reg       = s.rs;
      id_rs_used      = s.rsu;
      id_rt_reg       = s.rt;
      id_rt_used      = s.rtu;
      id_hlt          = s.hlt;
      id_branch_taken = s.br;
      if_busy         = s.ifb;
      mem_busy        = s.mb;
   endtask

   task automatic add(input stim_t s, input logic [7:0] v, input string name);
      vq.push_back('{s, v, name});
   endtask

   // Leaves the bench one time unit after a rising edge with idle inputs.
   task automatic do_reset();
      apply(idle_s());
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t  e;
      stim_t s;
      s = lu_s(4'd5);
      s.mb = 1'b1;
      apply(s);
      rst_n = 1'b0;
      sb.push_back('{V_RST, "reset_outputs"});
      @(negedge clk);
      e = sb.pop_front();
      n_asserts++;
      if (outs() !== e.v) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", e.name, outs(), e.v);
      end
`ifdef PIPE_CTRL_PERF_EN
      n_asserts++;
      if (perf_stall_cnt !== '0 || perf_flush_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_perf: got %0d/%0d required 0/0", perf_stall_cnt, perf_flush_cnt);
      end
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      apply(idle_s());
   endtask

   task automatic test_load_use();
      stim_t s;
      exp_t  e;
      vec_t  t;
      add(lu_s(4'd5), V_LU, "lu_rs_match");
      add(idle_s(), V_NORM, "lu_one_cycle");
      add(lu_s(4'd0), V_NORM, "lu_rd_zero");
      s = lu_s(4'd5); s.rsu = 1'b0;        add(s, V_NORM, "lu_rs_unused");
      s = lu_s(4'd5); s.wr = 1'b0;         add(s, V_NORM, "lu_no_write");
      s = lu_s(4'd5); s.ld = 1'b0;         add(s, V_NORM, "lu_not_load");
      s = lu_s(4'd5); s.rs = 4'd6;         add(s, V_NORM, "lu_reg_differ");
      s = lu_s(4'd7); s.rsu = 1'b0; s.rs = 4'd0; s.rt = 4'd7; s.rtu = 1'b1;
      add(s, V_LU, "lu_rt_match");
      s = lu_s(4'd5); s.ifb = 1'b1;        add(s, V_LU, "lu_over_ifbusy");
      add(idle_s(), V_NORM, "lu_idle");
      while (vq.size() > 0) begin
         t = vq.pop_front();
         apply(t.s);
         sb.push_back('{t.v, t.name});
         @(negedge clk);
         e = sb.pop_front();
         n_asserts++;
         if (outs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", e.name, outs(), e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_mem_freeze();
      stim_t s;
      exp_t  e;
      vec_t  t;
      s = lu_s(4'd5); s.mb = 1'b1;
      for (int i = 0; i < 4; i++) add(s, V_FRZ, $sformatf("freeze_%0d", i));
      add(lu_s(4'd5), V_LU, "freeze_then_lu");
      add(idle_s(), V_NORM, "freeze_release");
      s = idle_s(); s.mb = 1'b1; s.br = 1'b1; s.ifb = 1'b1;
      add(s, V_FRZ, "freeze_over_branch");
      add(idle_s(), V_NORM, "freeze_idle");
      while (vq.size() > 0) begin
         t = vq.pop_front();
         apply(t.s);
         sb.push_back('{t.v, t.name});
         @(negedge clk);
         e = sb.pop_front();
         n_asserts++;
         if (outs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", e.name, outs(), e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_branch();
      stim_t s;
      exp_t  e;
      vec_t  t;
      s = idle_s(); s.br = 1'b1; s.ifb = 1'b1; add(s, V_BR, "br_over_ifbusy");
      add(idle_s(), V_NORM, "br_done");
      s = idle_s(); s.ifb = 1'b1;              add(s, V_IFB, "if_busy_only");
      s = idle_s(); s.br = 1'b1;               add(s, V_BR, "br_only");
      s = lu_s(4'd3); s.br = 1'b1;             add(s, V_LU, "lu_over_branch");
      add(idle_s(), V_NORM, "br_idle");
      while (vq.size() > 0) begin
         t = vq.pop_front();
         apply(t.s);
         sb.push_back('{t.v, t.name});
         @(negedge clk);
         e = sb.pop_front();
         n_asserts++;
         if (outs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", e.name, outs(), e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_halt();
      stim_t s;
      exp_t  e;
      vec_t  t;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         if (pass == 0) begin
            s = lu_s(4'd2); s.hlt = 1'b1;      add(s, V_LU, "hlt_blocked_by_lu");
            s = idle_s(); s.hlt = 1'b1;        add(s, V_NORM, "hlt_in_id");
            s = idle_s(); s.br = 1'b1;         add(s, V_DRN, "drain1_br_ignored");
            add(idle_s(), V_DRN, "drain2");
            add(idle_s(), V_DRN, "drain3");
            add(idle_s(), V_HLT, "halted_after_3");
            add(lu_s(4'd4), V_HLT, "halted_holds");
         end else begin
            s = idle_s(); s.hlt = 1'b1;        add(s, V_NORM, "hlt_mb_in_id");
            add(idle_s(), V_DRN, "drain_mb1");
            s = idle_s(); s.mb = 1'b1;         add(s, V_FRZ, "drain_freeze1");
                                               add(s, V_FRZ, "drain_freeze2");
            add(idle_s(), V_DRN, "drain_mb2");
            add(idle_s(), V_DRN, "drain_mb3");
            add(idle_s(), V_HLT, "halted_after_5");
         end
         while (vq.size() > 0) begin
            t = vq.pop_front();
            apply(t.s);
            sb.push_back('{t.v, t.name});
            @(negedge clk);
            e = sb.pop_front();
            n_asserts++;
            if (outs() !== e.v) begin
               n_fail++;
               $display("FAIL %s: got %b required %b", e.name, outs(), e.v);
            end
            @(posedge clk);
            #1;
         end
      end
      do_reset();
   endtask

   task automatic test_reset_mid_drain();
      stim_t s;
      exp_t  e;
      vec_t  t;
      s = idle_s(); s.hlt = 1'b1;
      apply(s);
      @(posedge clk);
      #1 apply(idle_s());
      #2 rst_n = 1'b0;
      sb.push_back('{V_RST, "async_reset_mid_drain"});
      #1;
      e = sb.pop_front();
      n_asserts++;
      if (outs() !== e.v) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", e.name, outs(), e.v);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) add(idle_s(), V_NORM, $sformatf("run_after_reset_%0d", i));
      while (vq.size() > 0) begin
         t = vq.pop_front();
         apply(t.s);
         sb.push_back('{t.v, t.name});
         @(negedge clk);
         e = sb.pop_front();
         n_asserts++;
         if (outs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", e.name, outs(), e.v);
         end
         @(posedge clk);
         #1;
      end
   endtask

`ifdef PIPE_CTRL_PERF_EN
   task automatic test_perf();
      stim_t             s;
      logic [PERF_W-1:0] ps[$];
      logic [PERF_W-1:0] pf[$];
      logic [PERF_W-1:0] es, ef;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(lu_s(4'd6)); @(posedge clk); #1;
         apply(idle_s());   @(posedge clk); #1;
      end
      for (int i = 0; i < 2; i++) begin
         s = idle_s(); s.br = 1'b1;
         apply(s);          @(posedge clk); #1;
         apply(idle_s());   @(posedge clk); #1;
      end
      ps.push_back(PERF_W'(3));
      pf.push_back(PERF_W'(5));
      @(negedge clk);
      es = ps.pop_front();
      ef = pf.pop_front();
      n_asserts++;
      if (perf_stall_cnt !== es) begin
         n_fail++;
         $display("FAIL perf_stall_count: got %0d required %0d", perf_stall_cnt, es);
      end
      n_asserts++;
      if (perf_flush_cnt !== ef) begin
         n_fail++;
         $display("FAIL perf_flush_count: got %0d required %0d", perf_flush_cnt, ef);
      end
      @(posedge clk);
      #1;
      s = idle_s(); s.ifb = 1'b1;
      apply(s);
      ps.push_back('1);
      repeat (65540) @(posedge clk);
      #1 apply(idle_s());
      @(negedge clk);
      es = ps.pop_front();
      n_asserts++;
      if (perf_stall_cnt !== es) begin
         n_fail++;
         $display("FAIL perf_stall_saturate: got %h required %h", perf_stall_cnt, es);
      end
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_mem_freeze();
      test_branch();
      test_halt();
      test_reset_mid_drain();
`ifdef PIPE_CTRL_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
